// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock synchronous FIFO holding DEPTH words of DATA_WIDTH bits.
//   Writes and reads are qualified internally by the full/empty flags. A
//   write while full is dropped, and a read while empty is ignored.
//
//   Ports
//     clk       in   1           single clock; all state updates on rising edge
//     rst       in   1           synchronous, active-low reset
//     data_in   in   DATA_WIDTH  write data, captured on an accepted write
//     w_en      in   1           write request
//     r_en      in   1           read request
//     data_out  out  DATA_WIDTH  registered read data; holds between reads
//     full      out  1           DEPTH words stored
//     empty     out  1           no words stored
//
//   DEPTH must be a power of two >= 2. Each pointer carries one extra wrap
//   bit above the address bits. This lets full and empty be told apart when
//   the address bits are equal.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  w_en,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]        r_wr_ptr;
  logic [PTR_W:0]        r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic [PTR_W-1:0]      w_wr_addr;
  logic [PTR_W-1:0]      w_rd_addr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  assign w_wr_addr = r_wr_ptr[PTR_W-1:0];
  assign w_rd_addr = r_rd_ptr[PTR_W-1:0];

  // Flags decode only the registered pointers. This keeps them free of any
  // dependence on the same-cycle strobes.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_wr_addr == w_rd_addr) && (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);

  // When full and both strobes are high, only the read is accepted. The write
  // sees the pre-edge full flag and is dropped, and the same holds for empty.
  assign w_wr_acc = w_en && !w_full;
  assign w_rd_acc = r_en && !w_empty;

  // Storage is not cleared on reset. A write during reset is blocked so that
  // reset wins over any strobe in the same cycle.
  always_ff @(posedge clk) begin
    if (rst && w_wr_acc) begin
      r_mem[w_wr_addr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        r_data_out <= r_mem[w_rd_addr];
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  assign data_out = r_data_out;
  assign full     = w_full;
  assign empty    = w_empty;

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       w_en;
  logic       r_en;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int n_cmp;
  int n_bad;

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       w;
    logic       r;
    logic [7:0] d;
    logic [7:0] exp_do;
    logic       exp_full;
    logic       exp_empty;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rs, input logic w, input logic r,
                              input logic [7:0] d, input logic [7:0] edo,
                              input logic ef, input logic ee);
    vec_t v;
    v.rst = rs; v.w = w; v.r = r; v.d = d;
    v.exp_do = edo; v.exp_full = ef; v.exp_empty = ee;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic rs, input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    rst = rs; w_en = w; r_en = r; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [7:0] edo, input logic ef, input logic ee);
    chk({name, ".data_out"}, data_out, edo);
    chk({name, ".full"}, {7'd0, full}, {7'd0, ef});
    chk({name, ".empty"}, {7'd0, empty}, {7'd0, ee});
  endtask

  initial begin
    int full_seen;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;

    // Reset with both strobes high
    add(0, 1, 1, 8'h55, 8'h00, 0, 1);
    // Fill 0x10..0x17
    for (int i = 0; i < 8; i++) add(1, 1, 0, 8'h10 + 8'(i), 8'h00, (i == 7), 0);
    // Overflow write is dropped
    add(1, 1, 0, 8'hFF, 8'h00, 1, 0);
    // Drain in order
    for (int i = 0; i < 8; i++) add(1, 0, 1, 8'h00, 8'h10 + 8'(i), 0, (i == 7));
    // Underflow: data_out holds
    for (int i = 0; i < 3; i++) add(1, 0, 1, 8'h00, 8'h17, 0, 1);
    // Write then read 0xA5
    add(1, 1, 0, 8'hA5, 8'h17, 0, 0);
    add(1, 0, 1, 8'h00, 8'hA5, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].w, vecs[i].r, vecs[i].d);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_do, vecs[i].exp_full, vecs[i].exp_empty);
    end

    // Wrap-around: 5 in / 5 out, then a full 8 in / 8 out across the wrap
    for (int i = 0; i < 5; i++) step(1, 1, 0, 8'h30 + 8'(i));
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 8'h00);
      chk($sformatf("wrap5_rd%0d", i), data_out, 8'h30 + 8'(i));
    end
    chk("wrap5_empty", {7'd0, empty}, 8'd1);
    full_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 8'h20 + 8'(i));
      if (full) full_seen++;
    end
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, 8'h00);
      if (full) full_seen++;
      chk($sformatf("wrap8_rd%0d", i), data_out, 8'h20 + 8'(i));
    end
    chk("wrap8_full_count", 8'(full_seen), 8'd1);
    chk("wrap8_empty", {7'd0, empty}, 8'd1);

    // Simultaneous access with 3 words stored
    for (int i = 0; i < 3; i++) step(1, 1, 0, 8'h40 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 8'h43 + 8'(i));
      chk_all($sformatf("simul%0d", i), 8'h40 + 8'(i), 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 8'h00);
      chk_all($sformatf("simul_drain%0d", i), 8'h44 + 8'(i), 0, (i == 2));
    end

    // Simultaneous when full: read wins, write dropped
    for (int i = 0; i < 8; i++) step(1, 1, 0, 8'h50 + 8'(i));
    chk("full_before", {7'd0, full}, 8'd1);
    step(1, 1, 1, 8'hEE);
    chk_all("full_simul", 8'h50, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 1, 8'h00);
      chk_all($sformatf("full_drain%0d", i), 8'h51 + 8'(i), 0, (i == 6));
    end

    // Simultaneous when empty: write accepted, read ignored
    step(1, 1, 1, 8'h77);
    chk_all("empty_simul", 8'h57, 0, 0);
    step(1, 0, 1, 8'h00);
    chk_all("empty_simul_rd", 8'h77, 0, 1);

    // Reset mid-stream with 4 words stored
    for (int i = 0; i < 4; i++) step(1, 1, 0, 8'h60 + 8'(i));
    step(0, 1, 0, 8'h99);
    chk_all("mid_reset", 8'h00, 0, 1);
    step(1, 1, 0, 8'h70);
    chk_all("post_reset_wr", 8'h00, 0, 0);
    step(1, 0, 1, 8'h00);
    chk_all("post_reset_rd", 8'h70, 0, 1);

    step(1, 0, 0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
